autotype_sequencer: RTL and testbench
=====================================

AUTOTYPE_SEQUENCER -- requirements
Module: autotype_sequencer

Interface
REQ-001 Parameter clk_mhz, default 25, clock frequency in MHz.
REQ-002 Parameter step_ms, default 320, duration of one sequencer tick in ms.
REQ-003 Parameter reset_ticks, default 1, ticks n_reset_out is held low.
REQ-004 Parameter press_ticks, default 1, ticks each key is held high.
REQ-005 Parameter auto_start, default 1, run the script automatically after reset.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  system clock (pixel clock domain).
REQ-008 reset  input  1  synchronous active-high reset.
REQ-009 start  input  1  one-cycle pulse, restarts the script when not busy.
REQ-010 ps2clk  input  1  raw PS/2 clock line, asynchronous.
REQ-011 n_reset_out  output  1  active-low reset to the computer core.
REQ-012 key_b, key_c, key_enter  output  1 each  onboard-key emulation, active-high.
REQ-013 busy  output  1  script in progress.
REQ-014 done  output  1  script finished or aborted.

Function
REQ-015 Prescaler: tick pulses high for one cycle when its counter reaches clk_mhz*1000*step_ms-1; the counter then wraps to 0.
REQ-016 Prescaler clears to 0 on reset and on an accepted start; the first tick follows a full period.
REQ-017 States: IDLE, RST_HOLD, GAP, PRESS, DONE; all state changes happen only on tick, except start and abort.
REQ-018 RST_HOLD: n_reset_out=0 for reset_ticks ticks, then GAP with step index 0.
REQ-019 GAP: all keys 0 for the current step's pre_gap ticks, then PRESS.
REQ-020 PRESS: exactly one key, selected by the step's key code, is 1 for press_ticks ticks; then GAP with index+1, or DONE after the last step.
REQ-021 Script, 5 steps of {key, pre_gap}: {B,1},{C,1},{ENTER,1},{ENTER,1},{ENTER,3}.
REQ-022 At most one key output is high in any cycle; keys are registered and change only on state transitions.
REQ-023 busy=1 in RST_HOLD/GAP/PRESS; done=1 only in DONE; n_reset_out=0 only in RST_HOLD.
REQ-024 An accepted start (state IDLE or DONE) enters RST_HOLD on the next cycle with index 0; start while busy is ignored.
REQ-025 start and tick in the same cycle in DONE: start wins.
REQ-026 Tick counters are sized for the maximum of reset_ticks, press_ticks and pre_gap; no wrap within a phase.

Reset
REQ-027 With auto_start=1, reset yields RST_HOLD: n_reset_out=0, keys=0, busy=1, done=0, index 0, prescaler 0.
REQ-028 With auto_start=0, reset yields IDLE: n_reset_out=1, keys=0, busy=0, done=0.
REQ-029 Reset mid-script abandons the script immediately; no key stays high past the reset cycle.

Configuration
REQ-030 Macro AUTOTYPE_PS2_ABORT_EN, when defined:
- ps2clk passes through a two-flop synchronizer.
- A synchronized falling edge seen in GAP or PRESS drives all keys to 0 on the next cycle and enters DONE.
- The edge is ignored in RST_HOLD, IDLE and DONE.
REQ-031 Without AUTOTYPE_PS2_ABORT_EN, the ps2clk port exists but is unused, and the script always runs to completion.

Structure
REQ-032 Package autotype_pkg holds:
- the key-code enum (KEY_B, KEY_C, KEY_ENTER);
- the state enum;
- the script length constant;
- the script ROM contents as constants.
REQ-033 Sub-module autotype_tick implements the prescaler (REQ-015/016), with inputs clk, reset, clr and output tick.

Verification (clk_mhz=1, step_ms=1 -> tick every 1000 cycles; defaults otherwise)
REQ-034 Release reset at cycle 0 -> n_reset_out low for cycles 0..999; key_b high for cycles 2000..2999; key_c high for 4000..4999.
REQ-035 Full run -> key_enter high for 6000..6999, 8000..8999 and 12000..12999; done rises at cycle 13000 and busy falls with it.
REQ-036 start pulse at cycle 20000 -> n_reset_out low for 20001..21000; the sequence repeats offset by 20001.
REQ-037 start pulse at cycle 5000 (busy) -> no effect; the timeline is identical to REQ-035.
REQ-038 With AUTOTYPE_PS2_ABORT_EN, a ps2clk falling edge at cycle 6500 -> key_enter 0 and done=1 within 4 cycles, with no further key activity.
REQ-039 reset asserted at cycle 2500 for 1 cycle -> key_b 0 on the next cycle, and the timeline restarts from REQ-034.

Source files
------------

// File: rtl/autotype_pkg.sv
// Shared types and the fixed key script for the autotype sequencer.
package autotype_pkg;

    typedef enum logic [1:0] {
        KEY_B     = 2'd0,
        KEY_C     = 2'd1,
        KEY_ENTER = 2'd2
    } key_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_HOLD = 3'd1,
        ST_GAP      = 3'd2,
        ST_PRESS    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam int SCRIPT_LEN = 5;
    localparam int MAX_GAP    = 3;

    // Script ROM, step 0 in the least significant slot.
    localparam logic [SCRIPT_LEN-1:0][1:0] SCRIPT_KEYS = {
        KEY_ENTER, KEY_ENTER, KEY_ENTER, KEY_C, KEY_B
    };
    localparam logic [SCRIPT_LEN-1:0][1:0] SCRIPT_GAPS = {
        2'd3, 2'd1, 2'd1, 2'd1, 2'd1
    };

    function automatic key_t script_key(input logic [2:0] idx);
        return key_t'(SCRIPT_KEYS[idx]);
    endfunction

    function automatic int script_gap(input logic [2:0] idx);
        return int'(SCRIPT_GAPS[idx]);
    endfunction

    // Key code to {enter, c, b} one-hot output vector.
    function automatic logic [2:0] key_onehot(input key_t k);
        return 3'b001 << k;
    endfunction

endpackage

// File: rtl/autotype_tick.sv
// Free-running prescaler: one-cycle tick every PERIOD clocks, clearable.
module autotype_tick #(
    parameter int PERIOD = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == TW'(PERIOD - 1));

    // Next count: wrap after the terminal value, restart on clear.
    always_comb begin
        cnt_d = cnt_q + TW'(1);
        if (clr || tick) cnt_d = '0;
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/autotype_sequencer.sv
// Autotype sequencer: holds the core in reset, then types B, C and three
// ENTERs on the onboard-key lines. Optional macro AUTOTYPE_PS2_ABORT_EN
// aborts the script when real PS/2 keyboard activity is seen.
module autotype_sequencer
    import autotype_pkg::*;
#(
    parameter int clk_mhz     = 25,
    parameter int step_ms     = 320,
    parameter int reset_ticks = 1,
    parameter int press_ticks = 1,
    parameter int auto_start  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ps2clk,
    output logic n_reset_out,
    output logic key_b,
    output logic key_c,
    output logic key_enter,
    output logic busy,
    output logic done
);

    localparam int PERIOD = clk_mhz * 1000 * step_ms;
    localparam int MAXT_A = (reset_ticks > press_ticks) ? reset_ticks : press_ticks;
    localparam int MAXT   = (MAXT_A > MAX_GAP) ? MAXT_A : MAX_GAP;
    localparam int CW     = ($clog2(MAXT) > 0) ? $clog2(MAXT) : 1;
    localparam state_t RST_STATE = (auto_start != 0) ? ST_RST_HOLD : ST_IDLE;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] ph_q, ph_d;
    logic [2:0]    keys_q, keys_d;
    logic          tick, start_acc, ps2_fall;

    function automatic logic last_tick(input logic [CW-1:0] ph, input int n);
        return ph == CW'(n - 1);
    endfunction

    assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE);

    autotype_tick #(.PERIOD(PERIOD)) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (start_acc),
        .tick (tick)
    );

`ifdef AUTOTYPE_PS2_ABORT_EN
    // ps2clk: [0],[1] synchronizer, [2] previous synchronized value.
    logic [2:0] ps2_q;
    always_ff @(posedge clk) begin
        if (reset) ps2_q <= 3'b111;
        else       ps2_q <= {ps2_q[1:0], ps2clk};
    end
    assign ps2_fall = ps2_q[2] & ~ps2_q[1];
`else
    logic unused_ps2clk;
    assign unused_ps2clk = ps2clk;
    assign ps2_fall      = 1'b0;
`endif

    // Next state: phases advance on tick; start and abort override.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        keys_d  = keys_q;
        case (state_q)
            ST_RST_HOLD: if (tick) begin
                if (last_tick(ph_q, reset_ticks)) begin
                    state_d = ST_GAP;
                    idx_d   = '0;
                    ph_d    = '0;
                end else ph_d = ph_q + CW'(1);
            end
            ST_GAP: if (tick) begin
                if (last_tick(ph_q, script_gap(idx_q))) begin
                    state_d = ST_PRESS;
                    ph_d    = '0;
                    keys_d  = key_onehot(script_key(idx_q));
                end else ph_d = ph_q + CW'(1);
            end
            ST_PRESS: if (tick) begin
                if (last_tick(ph_q, press_ticks)) begin
                    keys_d = '0;
                    ph_d   = '0;
                    if (idx_q == 3'(SCRIPT_LEN - 1)) state_d = ST_DONE;
                    else begin
                        state_d = ST_GAP;
                        idx_d   = idx_q + 3'd1;
                    end
                end else ph_d = ph_q + CW'(1);
            end
            default: ;
        endcase
        if (ps2_fall && (state_q == ST_GAP || state_q == ST_PRESS)) begin
            state_d = ST_DONE;
            keys_d  = '0;
            ph_d    = '0;
        end
        if (start_acc) begin
            state_d = ST_RST_HOLD;
            idx_d   = '0;
            ph_d    = '0;
            keys_d  = '0;
        end
    end

    // State registers; reset abandons any script in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_STATE;
            idx_q   <= '0;
            ph_q    <= '0;
            keys_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ph_q    <= ph_d;
            keys_q  <= keys_d;
        end
    end

    assign n_reset_out = (state_q != ST_RST_HOLD);
    assign busy        = (state_q == ST_RST_HOLD) || (state_q == ST_GAP) || (state_q == ST_PRESS);
    assign done        = (state_q == ST_DONE);
    assign {key_enter, key_c, key_b} = keys_q;

endmodule

// File: tb/tb_autotype_sequencer.sv
// Directed bench for autotype_sequencer with a 1000-cycle tick.
module tb_autotype_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic ps2clk = 1'b1;
    logic n_reset_out, key_b, key_c, key_enter, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int base = 0;

    autotype_sequencer #(.clk_mhz(1), .step_ms(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ps2clk     (ps2clk),
        .n_reset_out(n_reset_out),
        .key_b      (key_b),
        .key_c      (key_c),
        .key_enter  (key_enter),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Move to the negedge of cycle base+rel (cycles are counted between posedges).
    task automatic at(input int rel);
        while (cyc < base + rel) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Checks every output: n_reset_out, b, c, enter, busy, done.
    task automatic chk_all(input string tag, input logic nr, input logic b,
                           input logic c, input logic e, input logic bu, input logic dn);
        chk({tag, ".nrst"}, n_reset_out, nr);
        chk({tag, ".b"}, key_b, b);
        chk({tag, ".c"}, key_c, c);
        chk({tag, ".enter"}, key_enter, e);
        chk({tag, ".busy"}, busy, bu);
        chk({tag, ".done"}, done, dn);
    endtask

    // Pulse reset at the current cycle; the next cycle becomes relative cycle 0.
    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        base = cyc;
    endtask

    initial begin
        // Initial reset: released so that cycle 0 is the first cycle after it.
        @(negedge clk);
        @(negedge clk);
        pulse_reset();

        chk_all("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        at(999);   chk_all("hold_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        at(1000);  chk_all("gap0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        at(1999);  chk("b_pre", key_b, 1'b0);
        at(2000);  chk_all("b_on", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        at(2999);  chk("b_last", key_b, 1'b1);
        at(3000);  chk("b_off", key_b, 1'b0);
        at(3999);  chk("c_pre", key_c, 1'b0);
        at(4000);  chk_all("c_on", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        at(4999);  chk("c_last", key_c, 1'b1);
        // Start while busy must be ignored.
        at(5000);  chk("c_off", key_c, 1'b0);
        start = 1'b1;
        at(5001);  start = 1'b0;
        chk_all("busy_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        at(5999);  chk("e1_pre", key_enter, 1'b0);
        at(6000);  chk_all("e1_on", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        at(6999);  chk("e1_last", key_enter, 1'b1);
        at(7000);  chk("e1_off", key_enter, 1'b0);
        at(8000);  chk("e2_on", key_enter, 1'b1);
        at(8999);  chk("e2_last", key_enter, 1'b1);
        at(9000);  chk("e2_off", key_enter, 1'b0);
        at(11999); chk("e3_pre", key_enter, 1'b0);
        at(12000); chk("e3_on", key_enter, 1'b1);
        at(12999); chk_all("e3_last", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        at(13000); chk_all("done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        at(16000); chk_all("done_stay", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Restart from DONE with a start pulse in cycle 20000.
        at(20000); start = 1'b1;
        at(20001); start = 1'b0;
        chk_all("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        at(21000); chk("rst1_end", n_reset_out, 1'b0);
        at(21001); chk("rst1_rel", n_reset_out, 1'b1);
        at(22000); chk("b1_pre", key_b, 1'b0);
        at(22001); chk("b1_on", key_b, 1'b1);
        at(22500); chk("b1_mid", key_b, 1'b1);

        // One-cycle reset mid-press: key drops at once, timeline restarts.
        pulse_reset();
        chk_all("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        at(999);   chk("rst2_end", n_reset_out, 1'b0);
        at(1000);  chk("rst2_rel", n_reset_out, 1'b1);
        at(1999);  chk("b2_pre", key_b, 1'b0);
        at(2000);  chk("b2_on", key_b, 1'b1);
        at(4000);  chk("c2_on", key_c, 1'b1);
        at(6000);  chk("e2a_on", key_enter, 1'b1);

`ifdef AUTOTYPE_PS2_ABORT_EN
        // Keyboard activity during the first ENTER press aborts the script.
        at(6500);  ps2clk = 1'b0;
        at(6504);  chk_all("abort", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        at(6520);  ps2clk = 1'b1;
        at(8000);  chk_all("abort_quiet", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        at(12000); chk("abort_quiet_e3", key_enter, 1'b0);
`else
        // ps2clk is unused: toggling it leaves the script running.
        at(6500);  ps2clk = 1'b0;
        at(6504);  chk_all("no_abort", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        at(6520);  ps2clk = 1'b1;
        at(12000); chk("e3b_on", key_enter, 1'b1);
        at(13000); chk_all("done2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
